tour_cmd: RTL and testbench

- Sequences playback of a solved knight's tour after the tour solver asserts done.
- Steps the solver's move index 0..NUM_MOVES-1 and reads each one-hot move.
- Splits each L-shaped move into two motion commands, vertical then horizontal, and issues them through the cmd/cmd_rdy handshake.
- When no tour is running, passes UART commands straight through to the motion controller.

---
 rtl/tour_cmd.sv | 141 ++++++++++++++
 tb/tb_tour_cmd.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/tour_cmd.sv
// Knight's-tour playback sequencer: walks the solver's move list and issues each
// L-move as a vertical then horizontal motion command, else passes UART commands through.
module tour_cmd #(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic             clr_cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             tour_busy,
  output logic             tour_err
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] hdg;
    logic [3:0] sq;
  } cmd_t;

  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_MOVES - 1);
  localparam logic [3:0]       OP_MOVE = 4'b0010;
  localparam logic [3:0]       OP_FANF = 4'b0011;
  localparam logic [7:0]       HDG_N   = 8'h00;
  localparam logic [7:0]       HDG_W   = 8'h3F;
  localparam logic [7:0]       HDG_S   = 8'h7F;
  localparam logic [7:0]       HDG_E   = 8'hBF;
  localparam logic [7:0]       RESP_STEP = 8'h5A;
  localparam logic [7:0]       RESP_DONE = 8'hA5;

  state_t     state, nxt;
  logic       rdy_flag;
  cmd_t       tour_cmd, horz_cmd;
  cmd_t       vert_dec, horz_dec;
  logic       dx_neg, dy_neg;
  logic [1:0] dx_mag, dy_mag;
  logic       last_idx;

  assign last_idx = (mv_indx == LAST);

  // Sign/magnitude decode of the one-hot move; the lowest set bit wins.
  always_comb begin
    dx_neg = 1'b0; dx_mag = 2'd0;
    dy_neg = 1'b0; dy_mag = 2'd0;
    casez (move)
      8'b???????1: begin dx_neg = 1'b0; dx_mag = 2'd1; dy_neg = 1'b0; dy_mag = 2'd2; end
      8'b??????10: begin dx_neg = 1'b1; dx_mag = 2'd1; dy_neg = 1'b0; dy_mag = 2'd2; end
      8'b?????100: begin dx_neg = 1'b1; dx_mag = 2'd2; dy_neg = 1'b0; dy_mag = 2'd1; end
      8'b????1000: begin dx_neg = 1'b1; dx_mag = 2'd2; dy_neg = 1'b1; dy_mag = 2'd1; end
      8'b???10000: begin dx_neg = 1'b1; dx_mag = 2'd1; dy_neg = 1'b1; dy_mag = 2'd2; end
      8'b??100000: begin dx_neg = 1'b0; dx_mag = 2'd1; dy_neg = 1'b1; dy_mag = 2'd2; end
      8'b?1000000: begin dx_neg = 1'b0; dx_mag = 2'd2; dy_neg = 1'b1; dy_mag = 2'd1; end
      8'b10000000: begin dx_neg = 1'b0; dx_mag = 2'd2; dy_neg = 1'b0; dy_mag = 2'd1; end
      default: ;
    endcase
  end

  assign vert_dec = '{op: OP_MOVE, hdg: dy_neg ? HDG_S : HDG_N, sq: {2'b00, dy_mag}};
  assign horz_dec = '{op: OP_FANF, hdg: dx_neg ? HDG_W : HDG_E, sq: {2'b00, dx_mag}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start_tour) nxt = FETCH;
      FETCH:   nxt = DECODE;
      DECODE:  nxt = (move == 8'h00) ? IDLE : VERT;
      VERT:    if (clr_cmd_rdy) nxt = WAIT_V;
      WAIT_V:  if (send_resp) nxt = HORZ;
      HORZ:    if (clr_cmd_rdy) nxt = WAIT_H;
      WAIT_H:  if (send_resp) nxt = last_idx ? IDLE : FETCH;
      default: nxt = IDLE;
    endcase
  end

  // Both halves of the move are captured at DECODE so the horizontal leg does not
  // depend on the solver still presenting the same move later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mv_indx  <= '0;
      rdy_flag <= 1'b0;
      tour_cmd <= '0;
      horz_cmd <= '0;
      tour_err <= 1'b0;
    end else begin
      tour_err <= 1'b0;
      case (state)
        IDLE: if (start_tour) mv_indx <= '0;
        DECODE: begin
          if (move == 8'h00) begin
            tour_err <= 1'b1;
            mv_indx  <= '0;
          end else begin
            tour_cmd <= vert_dec;
            horz_cmd <= horz_dec;
            rdy_flag <= 1'b1;
          end
        end
        VERT, HORZ: if (clr_cmd_rdy) rdy_flag <= 1'b0;
        WAIT_V: if (send_resp) begin
          tour_cmd <= horz_cmd;
          rdy_flag <= 1'b1;
        end
        WAIT_H: if (send_resp) mv_indx <= last_idx ? '0 : mv_indx + 1'b1;
        default: ;
      endcase
    end
  end

  // While busy the UART consume strobe is held off so its pending command survives.
  always_comb begin
    tour_busy = (state != IDLE);
    if (tour_busy) begin
      cmd              = tour_cmd;
      cmd_rdy          = rdy_flag;
      clr_cmd_rdy_UART = 1'b0;
      resp             = (state == WAIT_H && last_idx) ? RESP_DONE : RESP_STEP;
    end else begin
      cmd              = cmd_UART;
      cmd_rdy          = cmd_rdy_UART;
      clr_cmd_rdy_UART = clr_cmd_rdy;
      resp             = RESP_DONE;
    end
  end

endmodule

// File: tb/tb_tour_cmd.sv
// Directed bench for tour_cmd: registered solver model, hand-computed command table.
module tb_tour_cmd;
  localparam int NM = 24;

  logic        clk = 1'b0, rst = 1'b1, start_tour = 1'b0;
  logic [7:0]  move = 8'h00;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART = 16'h0000;
  logic        cmd_rdy_UART = 1'b0, clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy, clr_cmd_rdy = 1'b0, send_resp = 1'b0;
  logic [7:0]  resp;
  logic        tour_busy, tour_err;

  logic [7:0]  tbl  [0:NM-1];
  int          ktbl [0:NM-1];
  int          n_tests = 0, n_fail = 0;

  // Expected vertical / horizontal command for move bit k.
  logic [15:0] vexp [0:7] = '{16'h2002, 16'h2002, 16'h2001, 16'h27F1,
                              16'h27F2, 16'h27F2, 16'h27F1, 16'h2001};
  logic [15:0] hexp [0:7] = '{16'h3BF1, 16'h33F1, 16'h33F2, 16'h33F2,
                              16'h33F1, 16'h3BF1, 16'h3BF2, 16'h3BF2};

  tour_cmd #(.NUM_MOVES(NM), .IDX_W(5)) dut (
    .clk(clk), .rst(rst), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
    .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
    .resp(resp), .tour_busy(tour_busy), .tour_err(tour_err)
  );

  always #5 clk = ~clk;

  // Solver: move is registered from mv_indx, valid one clock after it changes.
  always @(posedge clk) move <= (mv_indx < NM) ? tbl[mv_indx] : 8'h00;

  task automatic tick; @(posedge clk); #1; endtask
  task automatic do_reset; rst = 1'b1; tick(); rst = 1'b0; tick(); endtask
  task automatic start; start_tour = 1'b1; tick(); start_tour = 1'b0; endtask
  task automatic wait_rdy(output int n);
    n = 0;
    while (!cmd_rdy && n < 60) begin tick(); n++; end
  endtask
  task automatic pulse_clr(input int d);
    repeat (d) tick();
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
  endtask
  task automatic pulse_resp(input int d);
    repeat (d) tick();
    send_resp = 1'b1; tick(); send_resp = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_tests++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_rdy got %b want 0", cmd_rdy); end
    n_tests++; if (tour_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", tour_busy); end
    n_tests++; if (mv_indx !== 5'd0) begin n_fail++; $display("FAIL rst_indx got %0d want 0", mv_indx); end
    n_tests++; if (tour_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", tour_err); end
    n_tests++; if (resp !== 8'hA5) begin n_fail++; $display("FAIL rst_resp got %h want a5", resp); end
    rst = 1'b0; tick(); tick();
    n_tests++; if (tour_busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy got %b want 0", tour_busy); end
  endtask

  task automatic test_passthru;
    cmd_UART = 16'h2003; cmd_rdy_UART = 1'b1; #1;
    n_tests++; if (cmd !== 16'h2003) begin n_fail++; $display("FAIL pt_cmd got %h want 2003", cmd); end
    n_tests++; if (cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL pt_rdy got %b want 1", cmd_rdy); end
    clr_cmd_rdy = 1'b1; #1;
    n_tests++; if (clr_cmd_rdy_UART !== 1'b1) begin n_fail++; $display("FAIL pt_clr got %b want 1", clr_cmd_rdy_UART); end
    n_tests++; if (resp !== 8'hA5) begin n_fail++; $display("FAIL pt_resp got %h want a5", resp); end
    clr_cmd_rdy = 1'b0; cmd_rdy_UART = 1'b0; #1;
    n_tests++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL pt_rdy_low got %b want 0", cmd_rdy); end
    tick();
  endtask

  task automatic test_single;
    int n;
    tbl[0] = 8'h01;
    tick(); tick();
    start();
    n_tests++; if (tour_busy !== 1'b1) begin n_fail++; $display("FAIL sg_busy got %b want 1", tour_busy); end
    wait_rdy(n);
    n_tests++; if (n != 2 || cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL sg_latency got %0d want 2", n); end
    n_tests++; if (cmd !== 16'h2002) begin n_fail++; $display("FAIL sg_vcmd got %h want 2002", cmd); end
    n_tests++; if (resp !== 8'h5A) begin n_fail++; $display("FAIL sg_resp got %h want 5a", resp); end
    pulse_resp(0);
    n_tests++; if (cmd_rdy !== 1'b1 || cmd !== 16'h2002) begin n_fail++; $display("FAIL sg_early_resp got %b/%h want 1/2002", cmd_rdy, cmd); end
    clr_cmd_rdy = 1'b1; send_resp = 1'b1; tick(); clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    tick(); tick(); tick();
    n_tests++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL sg_clr_only got %b want 0", cmd_rdy); end
    pulse_resp(0);
    n_tests++; if (cmd_rdy !== 1'b1 || cmd !== 16'h3BF1) begin n_fail++; $display("FAIL sg_hcmd got %b/%h want 1/3bf1", cmd_rdy, cmd); end
    do_reset();
  endtask

  task automatic test_tour(input bit rnd);
    int n, k, cmds;
    for (int i = 0; i < NM; i++) begin
      ktbl[i] = rnd ? int'($urandom_range(0, 7)) : (i % 8);
      tbl[i]  = 8'h01 << ktbl[i];
    end
    cmds = 0;
    tick(); tick();
    start();
    for (int i = 0; i < NM; i++) begin
      k = ktbl[i];
      wait_rdy(n);
      if (cmd_rdy) cmds++;
      n_tests++; if (n != 2 || cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL tour_lat i=%0d got %0d want 2", i, n); end
      n_tests++; if (cmd !== vexp[k]) begin n_fail++; $display("FAIL tour_vcmd i=%0d got %h want %h", i, cmd, vexp[k]); end
      n_tests++; if (mv_indx !== 5'(i)) begin n_fail++; $display("FAIL tour_indx got %0d want %0d", mv_indx, i); end
      pulse_clr(rnd ? int'($urandom_range(0, 20)) : 0);
      n_tests++; if (cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL tour_vclr i=%0d got %b want 0", i, cmd_rdy); end
      pulse_resp(rnd ? int'($urandom_range(0, 20)) : 0);
      wait_rdy(n);
      if (cmd_rdy) cmds++;
      n_tests++; if (cmd !== hexp[k] || n != 0) begin n_fail++; $display("FAIL tour_hcmd i=%0d got %h want %h", i, cmd, hexp[k]); end
      pulse_clr(rnd ? int'($urandom_range(0, 20)) : 0);
      n_tests++; if (resp !== ((i == NM-1) ? 8'hA5 : 8'h5A)) begin n_fail++; $display("FAIL tour_resp i=%0d got %h", i, resp); end
      pulse_resp(rnd ? int'($urandom_range(0, 20)) : 0);
    end
    n_tests++; if (cmds != 2*NM) begin n_fail++; $display("FAIL tour_count got %0d want %0d", cmds, 2*NM); end
    n_tests++; if (tour_busy !== 1'b0 || mv_indx !== 5'd0) begin n_fail++; $display("FAIL tour_end got %b/%0d want 0/0", tour_busy, mv_indx); end
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b1; #1;
    n_tests++; if (cmd !== 16'h1234 || cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL tour_uart got %h/%b want 1234/1", cmd, cmd_rdy); end
    cmd_rdy_UART = 1'b0;
    tick();
  endtask

  task automatic test_error;
    int n;
    for (int i = 0; i < NM; i++) tbl[i] = (i < 5) ? (8'h01 << i) : ((i == 5) ? 8'h00 : 8'h01);
    tick(); tick();
    start();
    wait_rdy(n);
    pulse_clr(0);
    start();
    n_tests++; if (tour_busy !== 1'b1 || mv_indx !== 5'd0 || cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL err_start_ignored got %b/%0d/%b", tour_busy, mv_indx, cmd_rdy); end
    cmd_UART = 16'hBEEF; cmd_rdy_UART = 1'b1; clr_cmd_rdy = 1'b1; #1;
    n_tests++; if (clr_cmd_rdy_UART !== 1'b0) begin n_fail++; $display("FAIL err_uart_clr got %b want 0", clr_cmd_rdy_UART); end
    n_tests++; if (cmd !== 16'h2002) begin n_fail++; $display("FAIL err_cmd_src got %h want 2002", cmd); end
    clr_cmd_rdy = 1'b0;
    pulse_resp(0);
    n_tests++; if (cmd !== 16'h3BF1) begin n_fail++; $display("FAIL err_h0 got %h want 3bf1", cmd); end
    pulse_clr(0); pulse_resp(0);
    for (int i = 1; i < 5; i++) begin
      wait_rdy(n); pulse_clr(0); pulse_resp(0);
      wait_rdy(n); pulse_clr(0); pulse_resp(0);
    end
    n_tests++; if (mv_indx !== 5'd5) begin n_fail++; $display("FAIL err_indx got %0d want 5", mv_indx); end
    tick(); tick();
    n_tests++; if (tour_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse got %b want 1", tour_err); end
    n_tests++; if (tour_busy !== 1'b0 || mv_indx !== 5'd0) begin n_fail++; $display("FAIL err_idle got %b/%0d want 0/0", tour_busy, mv_indx); end
    n_tests++; if (cmd_rdy !== 1'b1 || cmd !== 16'hBEEF) begin n_fail++; $display("FAIL err_uart_kept got %b/%h want 1/beef", cmd_rdy, cmd); end
    tick();
    n_tests++; if (tour_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_len got %b want 0", tour_err); end
    cmd_rdy_UART = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    int n;
    for (int i = 0; i < NM; i++) tbl[i] = 8'h01;
    tick(); tick();
    start();
    for (int i = 0; i < 10; i++) begin
      wait_rdy(n); pulse_clr(0); pulse_resp(0);
      wait_rdy(n); pulse_clr(0); pulse_resp(0);
    end
    wait_rdy(n); pulse_clr(0); pulse_resp(0);
    n_tests++; if (cmd_rdy !== 1'b1 || mv_indx !== 5'd10) begin n_fail++; $display("FAIL rm_horz got %b/%0d want 1/10", cmd_rdy, mv_indx); end
    #1 rst = 1'b1; #1;
    n_tests++; if (cmd_rdy !== 1'b0 || tour_busy !== 1'b0 || mv_indx !== 5'd0) begin n_fail++; $display("FAIL rm_async got %b/%b/%0d want 0/0/0", cmd_rdy, tour_busy, mv_indx); end
    #1 rst = 1'b0;
    tick(); tick();
    start();
    wait_rdy(n);
    n_tests++; if (n != 2 || cmd !== 16'h2002 || mv_indx !== 5'd0) begin n_fail++; $display("FAIL rm_replay got %0d/%h/%0d want 2/2002/0", n, cmd, mv_indx); end
    do_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NM; i++) tbl[i] = 8'h00;
    test_reset();
    test_passthru();
    test_single();
    test_tour(1'b0);
    test_tour(1'b1);
    test_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
